// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution accumulator datapath.
package conv_pkg;

  localparam int ACC_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

  localparam logic [ACC_W-1:0] SAT_POS = 24'h7FFFFF;
  localparam logic [ACC_W-1:0] SAT_NEG = 24'h800000;

endpackage

// File: rtl/adder24.sv
// 24-bit carry-lookahead adder: 4-bit lookahead groups with group carries chained.
module adder24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        cin,
  output logic [23:0] s,
  output logic        cout
);

  logic [23:0] g;
  logic [23:0] p;
  logic [23:0] carry;
  logic        cg;

  assign g = a & b;
  assign p = a ^ b;

  // Each group derives its internal carries from the incoming group carry only.
  always_comb begin
    carry = '0;
    cg    = cin;
    for (int k = 0; k < 6; k++) begin
      carry[4*k]   = cg;
      carry[4*k+1] = g[4*k] | (p[4*k] & cg);
      carry[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg);
      carry[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                   | (p[4*k+2] & p[4*k+1] & p[4*k] & cg);
      cg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cg);
    end
    cout = cg;
  end

  assign s = p ^ carry;

endmodule

// File: rtl/conv_accum24.sv
// Streaming signed window accumulator with bias seeding and valid/ready output.
// Define ACC_SAT_EN to clamp on signed overflow instead of wrapping.
module conv_accum24
  import conv_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MAX_BEATS = 1024,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [ACC_W-1:0]  bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_trunc,
  output logic              out_sat
);

  if (ACC_W != conv_pkg::ACC_W) begin : g_acc_w_check
    $error("conv_accum24: ACC_W must equal 24 to match adder24");
  end

  acc_state_t       state_q;
  acc_state_t       state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] op_a;
  logic [ACC_W-1:0] op_b;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q;
  logic             trunc_q;
  logic             accept;
  logic             at_limit;
  logic             close_win;
  logic             out_hs;

  assign in_ready  = (state_q != HOLD) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_hs    = (state_q == HOLD) && out_ready;

  // The first beat adds onto the bias, so one adder serves the whole window.
  assign op_a = (state_q == IDLE) ? bias : acc_q;
  assign op_b = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  adder24 u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .s    (sum),
    .cout ()
  );

  assign at_limit  = (state_q == IDLE) ? (MAX_BEATS == 1) : (cnt_q == CNT_W'(MAX_BEATS - 1));
  assign close_win = in_last || at_limit;

`ifdef ACC_SAT_EN
  logic ovf;
  logic sat_q;

  assign ovf      = (op_a[ACC_W-1] == op_b[ACC_W-1]) && (sum[ACC_W-1] != op_a[ACC_W-1]);
  assign acc_next = ovf ? (op_a[ACC_W-1] ? SAT_NEG : SAT_POS) : sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (accept) begin
      sat_q <= ovf || ((state_q == ACCUM) && sat_q);
    end else if (out_hs) begin
      sat_q <= 1'b0;
    end
  end

  assign out_sat = sat_q;
`else
  assign acc_next = sum;
  assign out_sat  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = close_win ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else if (accept) begin
      acc_q   <= acc_next;
      cnt_q   <= (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      trunc_q <= close_win && !in_last;
    end else if (out_hs) begin
      trunc_q <= 1'b0;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_conv_accum24.sv
// Directed bench for conv_accum24 (MAX_BEATS=4): vector table plus hand-written corner sequences.
module tb_conv_accum24;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 24;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [ACC_W-1:0]  bias;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_trunc;
  logic              out_sat;

  conv_accum24 #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0]      bias;
    logic [2:0]       n;
    logic             gap;
    logic [2:0]       hold;
    logic [3:0][15:0] d;
    logic [23:0]      exp_data;
    logic [2:0]       exp_count;
    logic             exp_sat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic [26:0] got_q[$];

  always @(negedge clk) begin
    if (mon_en && out_valid) got_q.push_back({out_data, out_count});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [23:0] b, input int n, input bit gap, input int hold,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [23:0] ed, input int ec, input bit es);
    vec_t v;
    v.bias      = b;
    v.n         = 3'(n);
    v.gap       = gap;
    v.hold      = 3'(hold);
    v.d[0]      = d0;
    v.d[1]      = d1;
    v.d[2]      = d2;
    v.d[3]      = d3;
    v.exp_data  = ed;
    v.exp_count = 3'(ec);
    v.exp_sat   = es;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Presents one beat and waits (bounded) until it is accepted on a rising edge.
  task automatic sendBeat(input logic [15:0] d, input logic last, input logic [23:0] b);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    bias     = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_timeout: in_ready=0 required=1 after %0d cycles", guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    bias     = 24'h0BAD00;
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      if (v.gap && i > 0) repeat (2) @(negedge clk);
      sendBeat(v.d[i], (i == int'(v.n) - 1), (i == 0) ? v.bias : 24'h5A5A5A);
    end
  endtask

  // Called right after the closing beat: checks the result one cycle later, then handshakes.
  task automatic checkOutput(input string tag, input logic [23:0] ed, input logic [2:0] ec,
                             input logic et, input logic es, input int hold);
    @(negedge clk);
    checkValue({tag, ".valid"}, out_valid, 1);
    checkValue({tag, ".data"},  out_data,  ed);
    checkValue({tag, ".count"}, out_count, ec);
    checkValue({tag, ".trunc"}, out_trunc, et);
    checkValue({tag, ".sat"},   out_sat,   es);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 16'h03E7;
      in_last  = 1'b1;
      @(negedge clk);
      checkValue({tag, ".hold_valid"}, out_valid, 1);
      checkValue({tag, ".hold_ready"}, in_ready,  0);
      checkValue({tag, ".hold_data"},  out_data,  ed);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkValue({tag, ".done_valid"}, out_valid, 0);
    checkValue({tag, ".done_ready"}, in_ready,  1);
  endtask

  vec_t        vecs[7];
  logic [26:0] exp_b2b[3];
  bit          seen_valid;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b0;

    vecs[0] = mk(24'd10,     1, 0, 0, 16'hFFFD, 16'h0,    16'h0,    16'h0, 24'd7,      1, 0);
    vecs[1] = mk(24'd0,      4, 1, 5, 16'd100,  16'hFFCE, 16'd25,   16'd1, 24'd76,     4, 0);
    vecs[2] = mk(24'hFFFF9C, 3, 0, 0, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'h0, 24'hFFFF96, 3, 0);
`ifdef ACC_SAT_EN
    vecs[3] = mk(24'h7FFF00, 2, 0, 0, 16'h7FFF, 16'h7FFF, 16'h0,    16'h0, 24'h7FFFFF, 2, 1);
    vecs[4] = mk(24'h800000, 1, 0, 0, 16'hFFFF, 16'h0,    16'h0,    16'h0, 24'h800000, 1, 1);
    vecs[6] = mk(24'h7FFFF0, 2, 0, 0, 16'h0100, 16'hFFF0, 16'h0,    16'h0, 24'h7FFFEF, 2, 1);
`else
    vecs[3] = mk(24'h7FFF00, 2, 0, 0, 16'h7FFF, 16'h7FFF, 16'h0,    16'h0, 24'h80FEFE, 2, 0);
    vecs[4] = mk(24'h800000, 1, 0, 0, 16'hFFFF, 16'h0,    16'h0,    16'h0, 24'h7FFFFF, 1, 0);
    vecs[6] = mk(24'h7FFFF0, 2, 0, 0, 16'h0100, 16'hFFF0, 16'h0,    16'h0, 24'h8000E0, 2, 0);
`endif
    vecs[5] = mk(24'h000123, 2, 1, 1, 16'h7FFF, 16'h8000, 16'h0,    16'h0, 24'h000122, 2, 0);

    repeat (2) @(negedge clk);
    checkValue("rst.in_ready",  in_ready,  0);
    checkValue("rst.out_valid", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    checkValue("post_rst.in_ready",  in_ready,  1);
    checkValue("post_rst.out_valid", out_valid, 0);
    checkValue("post_rst.out_data",  out_data,  0);
    checkValue("post_rst.out_count", out_count, 0);
    checkValue("post_rst.out_trunc", out_trunc, 0);
    checkValue("post_rst.out_sat",   out_sat,   0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_count, 1'b0,
                  vecs[i].exp_sat, int'(vecs[i].hold));
    end

    $display("[TB] max-beats truncation");
    sendBeat(16'd1, 1'b0, 24'd3);
    repeat (3) sendBeat(16'd1, 1'b0, 24'h5A5A5A);
    checkOutput("trunc", 24'd7, 3'd4, 1'b1, 1'b0, 0);
    sendBeat(16'd1, 1'b0, 24'd20);
    sendBeat(16'd1, 1'b1, 24'h5A5A5A);
    checkOutput("after_trunc", 24'd22, 3'd2, 1'b0, 1'b0, 0);

    $display("[TB] reset mid-window");
    sendBeat(16'd7, 1'b0, 24'd50);
    sendBeat(16'd7, 1'b0, 24'h5A5A5A);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkValue("midrst.in_ready", in_ready, 0);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checkValue("midrst.no_valid", seen_valid, 0);
    checkValue("midrst.count",    out_count,  0);
    sendBeat(16'd1, 1'b1, 24'd5);
    checkOutput("midrst.next", 24'd6, 3'd1, 1'b0, 1'b0, 0);

    $display("[TB] back-to-back windows");
    exp_b2b[0] = {24'd6,  3'd2};
    exp_b2b[1] = {24'd99, 3'd1};
    exp_b2b[2] = {24'd10, 3'd3};
    out_ready = 1'b1;
    mon_en    = 1'b1;
    sendBeat(16'd2,    1'b0, 24'd1);
    sendBeat(16'd3,    1'b1, 24'h5A5A5A);
    sendBeat(16'hFFFF, 1'b1, 24'd100);
    sendBeat(16'd5,    1'b0, 24'hFFFFFB);
    sendBeat(16'd5,    1'b0, 24'h5A5A5A);
    sendBeat(16'd5,    1'b1, 24'h5A5A5A);
    repeat (3) @(negedge clk);
    mon_en    = 1'b0;
    out_ready = 1'b0;
    checkValue("b2b.results", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) checkValue($sformatf("b2b.win%0d", i), got_q[i], exp_b2b[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
